// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Boot-time writer for the instruction memory. A byte stream from the
// host-link receiver carries a little-endian 16-bit instruction count N,
// followed by N three-byte groups. Each group becomes one 17-bit instruction
// word. Words are written to the instruction memory at sequential addresses
// starting from 0. The processor is held in reset until the whole image has
// been written.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - single-cycle pulse; begins a load from IDLE, DONE or ERR
//   rx_data   - byte from the host-link receiver
//   rx_valid  - rx_data is valid
//   rx_ready  - loader accepts a byte (transfer on rx_valid && rx_ready)
//   wr_en     - instruction memory write strobe, one cycle per word
//   wr_addr   - instruction memory write address
//   wr_data   - instruction memory write data
//   cpu_hold  - processor held in reset while high
//   done      - image fully written (level)
//   err       - image length exceeded depth (level)
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int width_in  = 11,
  parameter int width_out = 17,
  parameter int depth     = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [width_in-1:0]  wr_addr,
  output logic [width_out-1:0] wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(depth);

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          idx_q, idx_d;
  logic [15:0]          asm_q, asm_d;
  logic [width_in-1:0]  wr_addr_q, wr_addr_d;
  logic [width_out-1:0] wr_data_q, wr_data_d;

  logic                 rx_ready_int;
  logic                 take;
  logic [15:0]          n_full;

  // Byte acceptance is a pure function of the state, so the source sees a
  // stable ready for the whole cycle.
  assign rx_ready_int = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_B0) || (state_q == S_B1) ||
                        (state_q == S_B2);
  assign take   = rx_valid && rx_ready_int;
  assign n_full = {rx_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic. The write port registers are loaded on the third byte
  // transfer so that address and data are valid throughout the WRITE cycle
  // and then hold until the next word is complete.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          idx_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (take) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          len_d = n_full;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if (n_full > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (take) begin
          asm_d[7:0] = rx_data;
          state_d    = S_B1;
        end
      end
      S_B1: begin
        if (take) begin
          asm_d[15:8] = rx_data;
          state_d     = S_B2;
        end
      end
      S_B2: begin
        if (take) begin
          wr_addr_d = idx_q[width_in-1:0];
          wr_data_d = width_out'({rx_data[0], asm_q});
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // The index stops at N-1 so a full-depth image never wraps.
        if (idx_q == len_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_B0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. cpu_hold is released only while the image is complete.
  always_comb begin
    rx_ready = rx_ready_int;
    wr_en    = (state_q == S_WRITE);
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
    cpu_hold = (state_q != S_DONE);
  end

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. Images are streamed byte by byte;
// every write strobe is captured and compared against expected words taken
// either from a hand-written table or from a reference model that decodes
// the image format directly with arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [16:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  instr_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [16:0] word;
  } vec_t;

  vec_t vecs[8];

  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0] img[$];
  int   exp_words[$];
  bit   exp_done;
  bit   exp_err;
  int   got_addr[$];
  int   got_data[$];
  int   wr_cyc[$];
  int   done_cycle;
  int   last_take_cycle;
  bit   ready_in_write;
  bit   timed_out;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_rx_ready"}, rx_ready, 0);
    checkOutput({tag, "_wr_en"},    wr_en,    0);
    checkOutput({tag, "_wr_addr"},  wr_addr,  0);
    checkOutput({tag, "_wr_data"},  wr_data,  0);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
    checkOutput({tag, "_done"},     done,     0);
    checkOutput({tag, "_err"},      err,      0);
  endtask

  // Reference model: decode the image straight from the format rules.
  task automatic build_expected();
    int n;
    exp_words.delete();
    n = int'(img[0]) + 256 * int'(img[1]);
    exp_err  = (n > 2048);
    exp_done = !exp_err;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_words.push_back(int'(img[2 + 3*i]) + 256 * int'(img[3 + 3*i]) +
                            65536 * (int'(img[4 + 3*i]) % 2));
      end
    end
  endtask

  task automatic make_random_image(input int n);
    img.delete();
    img.push_back(8'(n % 256));
    img.push_back(8'(n / 256));
    for (int i = 0; i < 3*n; i++) img.push_back(8'($urandom));
  endtask

  task automatic load_table_image(input int first, input int count);
    img.delete();
    exp_words.delete();
    img.push_back(8'(count));
    img.push_back(8'h00);
    for (int i = first; i < first + count; i++) begin
      img.push_back(vecs[i].b0);
      img.push_back(vecs[i].b1);
      img.push_back(vecs[i].b2);
      exp_words.push_back(int'(vecs[i].word));
    end
    exp_done = 1'b1;
    exp_err  = 1'b0;
  endtask

  // Pulse start, then stream img. stall_mode: 0 = always valid,
  // 1 = valid pattern 1,0,0,1, 2 = random valid plus stray start pulses.
  // abort_after > 0 pulls reset once that many writes have been seen.
  task automatic applyStimulus(input int stall_mode, input int abort_after, input int max_cycles);
    int ptr;
    int cyc;
    bit v;
    got_addr.delete();
    got_data.delete();
    wr_cyc.delete();
    done_cycle      = -1;
    last_take_cycle = -1;
    ready_in_write  = 1'b0;
    timed_out       = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_cpu_hold", cpu_hold, 1);
    checkOutput("start_done",     done,     0);
    checkOutput("start_err",      err,      0);
    checkOutput("start_rx_ready", rx_ready, 1);

    ptr = 0;
    cyc = 0;
    forever begin
      if (wr_en) begin
        got_addr.push_back(int'(wr_addr));
        got_data.push_back(int'(wr_data));
        wr_cyc.push_back(cyc);
        if (rx_ready) ready_in_write = 1'b1;
      end
      if (abort_after > 0 && got_addr.size() == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        rx_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (done && done_cycle < 0) done_cycle = cyc;
      if (done || err) break;

      v = 1'b0;
      if (ptr < img.size()) begin
        case (stall_mode)
          0:       v = 1'b1;
          1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
      end
      rx_valid = v;
      rx_data  = v ? img[ptr] : 8'($urandom);
      if (v && rx_ready) begin
        ptr++;
        last_take_cycle = cyc;
      end
      start = (stall_mode == 2) && ($urandom_range(0, 15) == 0);

      @(negedge clk);
      cyc++;
      if (cyc > max_cycles) begin
        timed_out = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    checkOutput("bounded_finish", timed_out, 0);
  endtask

  task automatic check_results(input string tag, input bit check_spacing);
    int n;
    checkOutput({tag, "_write_count"}, got_addr.size(), exp_words.size());
    n = (got_addr.size() < exp_words.size()) ? got_addr.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_wr_addr[%0d]", tag, i), got_addr[i], i);
      checkOutput($sformatf("%s_wr_data[%0d]", tag, i), got_data[i], exp_words[i]);
    end
    if (check_spacing) begin
      for (int i = 1; i < wr_cyc.size(); i++) begin
        checkOutput($sformatf("%s_spacing[%0d]", tag, i), wr_cyc[i] - wr_cyc[i-1], 4);
      end
    end
    checkOutput({tag, "_done"},     done,     exp_done);
    checkOutput({tag, "_err"},      err,      exp_err);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    checkOutput({tag, "_rx_ready"}, rx_ready, 0);
    checkOutput({tag, "_no_take_in_write"}, ready_in_write, 0);
    if (exp_done) begin
      if (exp_words.size() > 0) begin
        if (wr_cyc.size() > 0)
          checkOutput({tag, "_done_latency"}, done_cycle, wr_cyc[wr_cyc.size()-1] + 1);
        checkOutput({tag, "_hold_addr"}, wr_addr, exp_words.size() - 1);
        checkOutput({tag, "_hold_data"}, wr_data, exp_words[exp_words.size()-1]);
      end else begin
        checkOutput({tag, "_done_latency"}, done_cycle, last_take_cycle + 1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hE4, 8'hFF, 8'h00, 17'h0FFE4};
    vecs[1] = '{8'h15, 8'h00, 8'h00, 17'h00015};
    vecs[2] = '{8'h1F, 8'h00, 8'h00, 17'h0001F};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 17'h1FFFF};
    vecs[4] = '{8'h00, 8'h00, 8'hFE, 17'h00000};
    vecs[5] = '{8'hAA, 8'h55, 8'h01, 17'h155AA};
    vecs[6] = '{8'h34, 8'h12, 8'h03, 17'h11234};
    vecs[7] = '{8'hC3, 8'h80, 8'h80, 17'h080C3};

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #23;
    check_reset_outputs("por_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    $display("[TB] basic three-word load");
    load_table_image(0, 3);
    applyStimulus(0, 0, 200);
    check_results("basic", 1'b1);

    $display("[TB] table image with 1,0,0,1 valid pattern");
    load_table_image(0, 8);
    applyStimulus(1, 0, 500);
    check_results("table", 1'b0);

    $display("[TB] zero-length image");
    img = '{8'h00, 8'h00};
    build_expected();
    applyStimulus(0, 0, 50);
    check_results("zero_len", 1'b0);

    $display("[TB] overflow image N=2049");
    img = '{8'h01, 8'h08};
    build_expected();
    applyStimulus(0, 0, 50);
    check_results("overflow", 1'b0);

    $display("[TB] full-depth image N=2048");
    make_random_image(2048);
    build_expected();
    applyStimulus(0, 0, 20000);
    check_results("full_depth", 1'b0);

    $display("[TB] randomized images with random stalls");
    for (int r = 0; r < 6; r++) begin
      make_random_image($urandom_range(1, 20));
      build_expected();
      applyStimulus(2, 0, 2000);
      check_results($sformatf("rand%0d", r), 1'b0);
    end

    $display("[TB] reset in the middle of a load");
    make_random_image(4);
    img[5] = 8'hA5;
    build_expected();
    applyStimulus(0, 2, 200);
    checkOutput("abort_writes", got_addr.size(), 2);
    if (got_addr.size() == 2) begin
      checkOutput("abort_addr1", got_addr[1], 1);
      checkOutput("abort_data1", got_data[1], exp_words[1]);
    end
    make_random_image(1);
    build_expected();
    applyStimulus(0, 0, 100);
    check_results("after_reset", 1'b0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
